// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM encoding,
// settle-count defaults and small decode helpers.
package alu_pkg;

  localparam logic [3:0] OP_DIV = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_NEG = 4'd9;
  localparam logic [3:0] OP_AND = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam int unsigned BASIC_CYCLES_DEF = 1;
  localparam int unsigned MUL_CYCLES_DEF   = 4;
  localparam int unsigned DIV_CYCLES_DEF   = 8;
  localparam int          CNT_W_DEF        = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_t;

  // PC increment is a plain adder path, so it always uses the basic settle time.
  function automatic int unsigned settle_cycles(input logic [3:0]  op,
                                                input logic        inc_pc,
                                                input int unsigned basic_c,
                                                input int unsigned mul_c,
                                                input int unsigned div_c);
    if (inc_pc)
      return basic_c;
    else if (op == OP_DIV)
      return div_c;
    else if (op == OP_MUL)
      return mul_c;
    return basic_c;
  endfunction

  // Codes above OP_NOT have no ALU function unless the PC-increment select overrides them.
  function automatic logic op_is_illegal(input logic [3:0] op, input logic inc_pc);
    return !inc_pc && (op > OP_NOT);
  endfunction

  // Only divide and multiply drive the upper half of Z.
  function automatic logic op_is_wide(input logic [3:0] op, input logic inc_pc);
    return !inc_pc && ((op == OP_DIV) || (op == OP_MUL));
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter timing the ALU settle window; term flags the last cycle.
module alu_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] count;

  // Load takes priority over counting; the counter parks at zero.
  always_ff @(posedge Clk) begin
    if (Clr)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign term = (count == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through the shared 32-bit ALU: latch operands,
// wait a per-opcode settle time, capture Z, hold it until the consumer takes it.
// Build option: define ALU_SEQ_DIV0_TRAP_EN to answer divide-by-zero directly
// with an error response instead of stepping the ALU.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready for a request; ALU operand registers hold last values
// ST_EXEC    | operands stable on the ALU, settle counter running
// ST_CAPTURE | ALU settled; Z is sampled on this cycle's edge
// ST_RESP    | result (or error) presented until resp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BASIC_CYCLES = BASIC_CYCLES_DEF,
  parameter int unsigned MUL_CYCLES   = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES   = DIV_CYCLES_DEF,
  parameter int          CNT_W        = CNT_W_DEF
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_inc_pc,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [3:0]  alu_control,
  output logic        alu_inc_pc,
  input  logic [31:0] alu_z_high,
  input  logic [31:0] alu_z_low,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        busy,
  output logic        err_illegal
);

  seq_state_t       state, state_next;
  logic             accept;
  logic             op_illegal;
  logic             div0_trap;
  logic             start_exec;
  logic             start_err;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt_load_val;

  assign accept     = req_valid && (state == ST_IDLE);
  assign op_illegal = op_is_illegal(req_op, req_inc_pc);

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign div0_trap = !req_inc_pc && (req_op == OP_DIV) && (req_b == '0);
`else
  assign div0_trap = 1'b0;
`endif

  // Error responses skip the ALU entirely and go straight to RESP.
  assign start_exec   = accept && !op_illegal && !div0_trap;
  assign start_err    = accept && (op_illegal || div0_trap);
  assign cnt_load_val = CNT_W'(settle_cycles(req_op, req_inc_pc,
                                             BASIC_CYCLES, MUL_CYCLES, DIV_CYCLES));

  alu_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .Clk      (Clk),
    .Clr      (Clr),
    .load     (start_exec),
    .load_val (cnt_load_val),
    .en       (state == ST_EXEC),
    .term     (cnt_term)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Clr)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (start_exec)
          state_next = ST_EXEC;
        else if (start_err)
          state_next = ST_RESP;
      end
      ST_EXEC: begin
        if (cnt_term)
          state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand, result and error registers.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      alu_reg1    <= '0;
      alu_reg2    <= '0;
      alu_control <= OP_ADD;
      alu_inc_pc  <= 1'b0;
      z_high      <= '0;
      z_low       <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (start_exec) begin
        alu_reg1    <= req_a;
        alu_reg2    <= req_b;
        alu_control <= req_op;
        alu_inc_pc  <= req_inc_pc;
      end
      if (start_err) begin
        err_illegal <= 1'b1;
        if (div0_trap) begin
          z_high <= req_a;
          z_low  <= '1;
        end else begin
          z_high <= '0;
          z_low  <= '0;
        end
      end
      if (state == ST_CAPTURE) begin
        z_low <= alu_z_low;
        if (op_is_wide(alu_control, alu_inc_pc))
          z_high <= alu_z_high;
      end
      if ((state == ST_RESP) && resp_ready)
        err_illegal <= 1'b0;
    end
  end

endmodule
